mips32_core: RTL and testbench

MIPS32_CORE -- requirements
Module: mips32_core

---
 rtl/mips32_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mips32_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_core.sv
// mips32_core: 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
// The register file and the unified instruction/data memory are plain arrays
// (regfile, mem) so that a bench can preload them hierarchically.
// Build option: define MIPS32_MUL_EN to include the MUL instruction; without
// it, opcode 000101 behaves as a NOP and no multiplier is built.
// Control flags that are all zero in a pipeline register mean a bubble.
module mips32_core (
   input  logic        clk,
   input  logic        rst,
   output logic        halted,
   output logic [31:0] pc
);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
`ifdef MIPS32_MUL_EN
   localparam logic [5:0] OP_MUL   = 6'b000101;
`endif
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   logic [31:0] regfile [0:31];
   logic [31:0] mem     [0:1023];

   // IF/ID
   logic        r_ifidValid;
   logic [31:0] r_ifidIr;
   logic [31:0] r_ifidPc;

   // ID/EX
   logic [5:0]  r_idexOp;
   logic [4:0]  r_idexRs;
   logic [4:0]  r_idexRt;
   logic [4:0]  r_idexDst;
   logic        r_idexRegWrite;
   logic        r_idexIsLw;
   logic        r_idexIsSw;
   logic        r_idexIsBr;
   logic        r_idexIsHlt;
   logic [31:0] r_idexA;
   logic [31:0] r_idexB;
   logic [31:0] r_idexImm;
   logic [31:0] r_idexPc;

   // EX/MEM
   logic        r_exmemRegWrite;
   logic        r_exmemIsLw;
   logic        r_exmemIsSw;
   logic        r_exmemIsHlt;
   logic [4:0]  r_exmemDst;
   logic [31:0] r_exmemVal;
   logic [31:0] r_exmemStore;

   // MEM/WB
   logic        r_memwbRegWrite;
   logic        r_memwbIsHlt;
   logic [4:0]  r_memwbDst;
   logic [31:0] r_memwbVal;

   // Set once an unflushed HLT has left ID; fetch stays stopped until reset
   logic        r_fetchStop;

   // Decode fields
   logic [5:0]  w_idOp;
   logic [4:0]  w_idRs;
   logic [4:0]  w_idRt;
   logic [4:0]  w_idRd;
   logic [31:0] w_idImm;
   logic        w_idIsR;
   logic        w_idIsIAlu;
   logic        w_idIsLw;
   logic        w_idIsSw;
   logic        w_idIsBr;
   logic        w_idIsHlt;
   logic        w_idUsesRs;
   logic        w_idUsesRt;
   logic [4:0]  w_idDst;
   logic        w_idRegWrite;
   logic [31:0] w_idA;
   logic [31:0] w_idB;
   logic        w_stall;

   logic [31:0] w_exA;
   logic [31:0] w_exB;
   logic [31:0] w_exAlu;
   logic        w_brTaken;
   logic [31:0] w_brTarget;

   logic [31:0] w_ifIr;
   logic [31:0] w_memRdata;
   logic [31:0] w_memResult;

   assign w_idOp  = r_ifidIr[31:26];
   assign w_idRs  = r_ifidIr[25:21];
   assign w_idRt  = r_ifidIr[20:16];
   assign w_idRd  = r_ifidIr[15:11];
   assign w_idImm = {{16{r_ifidIr[15]}}, r_ifidIr[15:0]};

   // Classify the instruction in ID; unknown opcodes (and MUL when it is not
   // built) fall through with every flag low and so travel as NOPs
   always_comb begin
      w_idIsR    = 1'b0;
      w_idIsIAlu = 1'b0;
      w_idIsLw   = 1'b0;
      w_idIsSw   = 1'b0;
      w_idIsBr   = 1'b0;
      w_idIsHlt  = 1'b0;
      if (r_ifidValid) begin
         case (w_idOp)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: w_idIsR = 1'b1;
`ifdef MIPS32_MUL_EN
            OP_MUL:                                w_idIsR = 1'b1;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             w_idIsIAlu = 1'b1;
            OP_LW:                                 w_idIsLw = 1'b1;
            OP_SW:                                 w_idIsSw = 1'b1;
            OP_BNEQZ, OP_BEQZ:                     w_idIsBr = 1'b1;
            OP_HLT:                                w_idIsHlt = 1'b1;
            default: ;
         endcase
      end
   end

   assign w_idUsesRs   = w_idIsR | w_idIsIAlu | w_idIsLw | w_idIsSw | w_idIsBr;
   assign w_idUsesRt   = w_idIsR | w_idIsSw;
   assign w_idDst      = w_idIsR ? w_idRd : w_idRt;
   assign w_idRegWrite = (w_idIsR | w_idIsIAlu | w_idIsLw) && (w_idDst != 5'd0);

   // Register read sees a same-cycle WB write, as if the write happened in
   // the first half of the cycle; r0 always reads as zero
   assign w_idA = (w_idRs == 5'd0) ? 32'd0 :
                  (r_memwbRegWrite && r_memwbDst == w_idRs) ? r_memwbVal : regfile[w_idRs];
   assign w_idB = (w_idRt == 5'd0) ? 32'd0 :
                  (r_memwbRegWrite && r_memwbDst == w_idRt) ? r_memwbVal : regfile[w_idRt];

   // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle
   assign w_stall = r_idexIsLw && r_idexRegWrite &&
                    ((w_idUsesRs && w_idRs == r_idexDst) || (w_idUsesRt && w_idRt == r_idexDst));

   // Operand forwarding into EX: EX/MEM is younger than MEM/WB so it is tried first;
   // a load in EX/MEM only holds its address, never its data
   always_comb begin
      w_exA = r_idexA;
      if (r_exmemRegWrite && !r_exmemIsLw && r_exmemDst == r_idexRs) begin
         w_exA = r_exmemVal;
      end else if (r_memwbRegWrite && r_memwbDst == r_idexRs) begin
         w_exA = r_memwbVal;
      end
      w_exB = r_idexB;
      if (r_exmemRegWrite && !r_exmemIsLw && r_exmemDst == r_idexRt) begin
         w_exB = r_exmemVal;
      end else if (r_memwbRegWrite && r_memwbDst == r_idexRt) begin
         w_exB = r_memwbVal;
      end
   end

   // ALU: register ops, immediate ops and effective-address generation
   always_comb begin
      w_exAlu = 32'd0;
      case (r_idexOp)
         OP_ADD:                 w_exAlu = w_exA + w_exB;
         OP_SUB:                 w_exAlu = w_exA - w_exB;
         OP_AND:                 w_exAlu = w_exA & w_exB;
         OP_OR:                  w_exAlu = w_exA | w_exB;
         OP_SLT:                 w_exAlu = {31'd0, ($signed(w_exA) < $signed(w_exB))};
`ifdef MIPS32_MUL_EN
         OP_MUL:                 w_exAlu = w_exA * w_exB;
`endif
         OP_ADDI, OP_LW, OP_SW:  w_exAlu = w_exA + r_idexImm;
         OP_SUBI:                w_exAlu = w_exA - r_idexImm;
         OP_SLTI:                w_exAlu = {31'd0, ($signed(w_exA) < $signed(r_idexImm))};
         default:                w_exAlu = 32'd0;
      endcase
   end

   assign w_brTaken  = r_idexIsBr &&
                       (((r_idexOp == OP_BNEQZ) && (w_exA != 32'd0)) ||
                        ((r_idexOp == OP_BEQZ)  && (w_exA == 32'd0)));
   assign w_brTarget = r_idexPc + 32'd1 + r_idexImm;

   assign w_ifIr      = mem[pc[9:0]];
   assign w_memRdata  = mem[r_exmemVal[9:0]];
   assign w_memResult = r_exmemIsLw ? w_memRdata : r_exmemVal;

   // Pipeline advance: branch flush beats load-use stall, which beats the halt
   // freeze; once halted, nothing moves until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc              <= 32'd0;
         halted          <= 1'b0;
         r_fetchStop     <= 1'b0;
         r_ifidValid     <= 1'b0;
         r_idexRegWrite  <= 1'b0;
         r_idexIsLw      <= 1'b0;
         r_idexIsSw      <= 1'b0;
         r_idexIsBr      <= 1'b0;
         r_idexIsHlt     <= 1'b0;
         r_exmemRegWrite <= 1'b0;
         r_exmemIsLw     <= 1'b0;
         r_exmemIsSw     <= 1'b0;
         r_exmemIsHlt    <= 1'b0;
         r_memwbRegWrite <= 1'b0;
         r_memwbIsHlt    <= 1'b0;
      end else if (!halted) begin
         if (r_memwbIsHlt) begin
            halted <= 1'b1;
         end

         r_memwbRegWrite <= r_exmemRegWrite;
         r_memwbIsHlt    <= r_exmemIsHlt;
         r_memwbDst      <= r_exmemDst;
         r_memwbVal      <= w_memResult;

         r_exmemRegWrite <= r_idexRegWrite;
         r_exmemIsLw     <= r_idexIsLw;
         r_exmemIsSw     <= r_idexIsSw;
         r_exmemIsHlt    <= r_idexIsHlt;
         r_exmemDst      <= r_idexDst;
         r_exmemVal      <= w_exAlu;
         r_exmemStore    <= w_exB;

         if (w_brTaken) begin
            pc             <= w_brTarget;
            r_ifidValid    <= 1'b0;
            r_idexRegWrite <= 1'b0;
            r_idexIsLw     <= 1'b0;
            r_idexIsSw     <= 1'b0;
            r_idexIsBr     <= 1'b0;
            r_idexIsHlt    <= 1'b0;
         end else if (w_stall) begin
            r_idexRegWrite <= 1'b0;
            r_idexIsLw     <= 1'b0;
            r_idexIsSw     <= 1'b0;
            r_idexIsBr     <= 1'b0;
            r_idexIsHlt    <= 1'b0;
         end else begin
            r_idexOp       <= w_idOp;
            r_idexRs       <= w_idRs;
            r_idexRt       <= w_idRt;
            r_idexDst      <= w_idDst;
            r_idexRegWrite <= w_idRegWrite;
            r_idexIsLw     <= w_idIsLw;
            r_idexIsSw     <= w_idIsSw;
            r_idexIsBr     <= w_idIsBr;
            r_idexIsHlt    <= w_idIsHlt;
            r_idexA        <= w_idA;
            r_idexB        <= w_idB;
            r_idexImm      <= w_idImm;
            r_idexPc       <= r_ifidPc;
            if (r_fetchStop || w_idIsHlt) begin
               r_fetchStop <= 1'b1;
               r_ifidValid <= 1'b0;
            end else begin
               pc          <= pc + 32'd1;
               r_ifidValid <= 1'b1;
               r_ifidIr    <= w_ifIr;
               r_ifidPc    <= pc;
            end
         end
      end
   end

   // Register file write-back; r0 is never written and reset drops the write
   always_ff @(posedge clk) begin
      if (!rst && !halted && r_memwbRegWrite) begin
         regfile[r_memwbDst] <= r_memwbVal;
      end
   end

   // Data memory store in MEM; reset drops the store
   always_ff @(posedge clk) begin
      if (!rst && !halted && r_exmemIsSw) begin
         mem[r_exmemVal[9:0]] <= r_exmemStore;
      end
   end

endmodule

// File: tb/tb_mips32_core.sv
// tb_mips32_core: directed programs plus randomized programs checked against
// an instruction-at-a-time reference interpreter kept in this bench.
module tb_mips32_core;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;
   localparam logic [31:0] HLT_WORD = {6'b111111, 26'd0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halted;
   logic [31:0] pc;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] progMem [0:1023];
   logic [31:0] progReg [0:31];
   logic [31:0] mMem    [0:1023];
   logic [31:0] mReg    [0:31];

   mips32_core dut (
      .clk   (clk),
      .rst   (rst),
      .halted(halted),
      .pc    (pc)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Single comparison point; every check counts here and mismatches are reported
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [31:0] encR(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] encI(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic clearImage();
      for (int i = 0; i < 1024; i++) progMem[i] = 32'd0;
      for (int i = 0; i < 32; i++)   progReg[i] = 32'd0;
   endtask

   // Hold reset, copy the program image into the core, check the reset state, release
   task automatic applyStimulus(input string tag);
      rst = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 1024; i++) dut.mem[i] <= progMem[i];
      for (int i = 0; i < 32; i++)   dut.regfile[i] <= progReg[i];
      @(posedge clk);
      #1;
      checkOutput({tag, "_resetPc"}, pc, 32'd0);
      checkOutput({tag, "_resetHalted"}, {31'd0, halted}, 32'd0);
      rst = 1'b0;
   endtask

   // Wait, bounded, for the core to halt; returns cycles taken
   task automatic runToHalt(input string tag, output int cycles);
      cycles = 0;
      while (halted !== 1'b1 && cycles < 4000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd1);
   endtask

   // Reference interpreter: executes the image one instruction at a time
   task automatic runModel(output logic [31:0] expPc);
      logic [31:0] mpc, ir, a, b, imm, ea, res;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      bit          done;
      int          steps;
      for (int i = 0; i < 1024; i++) mMem[i] = progMem[i];
      for (int i = 0; i < 32; i++)   mReg[i] = progReg[i];
      mReg[0] = 32'd0;
      mpc = 32'd0; done = 1'b0; steps = 0; expPc = 32'hFFFF_FFFF;
      while (!done && steps < 5000) begin
         ir  = mMem[mpc[9:0]];
         op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
         imm = {{16{ir[15]}}, ir[15:0]};
         a   = mReg[rs]; b = mReg[rt];
         ea  = a + imm;
         case (op)
            OP_ADD:  mReg[rd] = a + b;
            OP_SUB:  mReg[rd] = a - b;
            OP_AND:  mReg[rd] = a & b;
            OP_OR:   mReg[rd] = a | b;
            OP_SLT:  mReg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MIPS32_MUL_EN
            OP_MUL:  begin res = a * b; mReg[rd] = res; end
`endif
            OP_LW:   mReg[rt] = mMem[ea[9:0]];
            OP_SW:   mMem[ea[9:0]] = b;
            OP_ADDI: mReg[rt] = a + imm;
            OP_SUBI: mReg[rt] = a - imm;
            OP_SLTI: mReg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_HLT:  begin done = 1'b1; expPc = mpc + 32'd1; end
            default: ;
         endcase
         mReg[0] = 32'd0;
         if (!done) begin
            if ((op == OP_BNEQZ && a != 32'd0) || (op == OP_BEQZ && a == 32'd0))
               mpc = mpc + 32'd1 + imm;
            else
               mpc = mpc + 32'd1;
         end
         steps++;
      end
   endtask

   task automatic loadDivision();
      clearImage();
      progMem[0]   = encI(OP_LW,    5'd0, 5'd1, 16'd100);
      progMem[1]   = encI(OP_LW,    5'd0, 5'd2, 16'd101);
      progMem[2]   = encR(OP_ADD,   5'd0, 5'd0, 5'd3);
      progMem[3]   = encR(OP_SLT,   5'd1, 5'd2, 5'd5);
      progMem[4]   = encI(OP_BNEQZ, 5'd5, 5'd0, 16'd3);
      progMem[5]   = encR(OP_SUB,   5'd1, 5'd2, 5'd1);
      progMem[6]   = encI(OP_ADDI,  5'd3, 5'd3, 16'd1);
      progMem[7]   = encI(OP_BEQZ,  5'd0, 5'd0, 16'hFFFB);
      progMem[8]   = encR(OP_ADD,   5'd1, 5'd0, 5'd4);
      progMem[9]   = HLT_WORD;
      progMem[100] = 32'd23;
      progMem[101] = 32'd5;
   endtask

   // Main sequence: directed scenarios first, then randomized programs
   initial begin
      int          cyc, cycA, cycB;
      logic [31:0] expPc;
      logic [5:0]  rop;
      string       tg;

      // Division by repeated subtraction, then check the halt freeze
      loadDivision();
      applyStimulus("div");
      runToHalt("div", cyc);
      checkOutput("div_r3", dut.regfile[3], 32'd4);
      checkOutput("div_r4", dut.regfile[4], 32'd3);
      checkOutput("div_pc", pc, 32'd10);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("div_pcFrozen", pc, 32'd10);
      checkOutput("div_haltedHeld", {31'd0, halted}, 32'd1);

      // Reset in the middle of the loop, then rerun
      loadDivision();
      applyStimulus("rstMid");
      repeat (25) @(posedge clk);
      #1;
      checkOutput("rstMid_notYetHalted", {31'd0, halted}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstMid_pc", pc, 32'd0);
      checkOutput("rstMid_halted", {31'd0, halted}, 32'd0);
      rst = 1'b0;
      runToHalt("rstMid", cyc);
      checkOutput("rstMid_r3", dut.regfile[3], 32'd4);
      checkOutput("rstMid_r4", dut.regfile[4], 32'd3);

      // Back-to-back dependency through forwarding
      clearImage();
      progMem[0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd7);
      progMem[1] = encR(OP_ADD,  5'd1, 5'd1, 5'd2);
      progMem[2] = HLT_WORD;
      applyStimulus("fwd");
      runToHalt("fwd", cyc);
      checkOutput("fwd_r2", dut.regfile[2], 32'd14);

      // Load-use: dependent program takes exactly one cycle more than independent one
      clearImage();
      progReg[5] = 32'd100; progReg[6] = 32'd50; progMem[100] = 32'd9;
      progMem[0] = encI(OP_LW,   5'd5, 5'd1, 16'd0);
      progMem[1] = encI(OP_ADDI, 5'd1, 5'd2, 16'd1);
      progMem[2] = HLT_WORD;
      applyStimulus("ldUse");
      runToHalt("ldUse", cycA);
      checkOutput("ldUse_r2", dut.regfile[2], 32'd10);
      progMem[1] = encI(OP_ADDI, 5'd6, 5'd2, 16'd1);
      applyStimulus("ldNoUse");
      runToHalt("ldNoUse", cycB);
      checkOutput("ldNoUse_r2", dut.regfile[2], 32'd51);
      checkOutput("ldUse_stallCycles", 32'(cycA - cycB), 32'd1);

      // Taken branch flushes the two younger instructions
      clearImage();
      progMem[0] = encI(OP_BEQZ, 5'd0, 5'd0, 16'd2);
      progMem[1] = encI(OP_ADDI, 5'd0, 5'd9, 16'd5);
      progMem[2] = encI(OP_ADDI, 5'd0, 5'd9, 16'd6);
      progMem[3] = encI(OP_ADDI, 5'd0, 5'd10, 16'd3);
      progMem[4] = HLT_WORD;
      applyStimulus("br");
      runToHalt("br", cyc);
      checkOutput("br_r9", dut.regfile[9], 32'd0);
      checkOutput("br_r10", dut.regfile[10], 32'd3);
      checkOutput("br_pc", pc, 32'd5);

      // MUL present or absent depending on the build
      clearImage();
      progReg[1] = 32'd6; progReg[2] = 32'd7; progReg[3] = 32'd99;
      progMem[0] = encR(OP_MUL, 5'd1, 5'd2, 5'd3);
      progMem[1] = HLT_WORD;
      applyStimulus("mul");
      runToHalt("mul", cyc);
`ifdef MIPS32_MUL_EN
      checkOutput("mul_r3", dut.regfile[3], 32'd42);
`else
      checkOutput("mul_r3", dut.regfile[3], 32'd99);
`endif

      // Randomized programs against the reference interpreter
      for (int t = 0; t < 12; t++) begin
         int n;
         clearImage();
         for (int r = 1; r < 8; r++) progReg[r] = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
         for (int d = 200; d < 232; d++) progMem[d] = $urandom;
         n = 24 + int'($urandom_range(0, 8));
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 9: begin
                  rop = 6'($urandom_range(0, 5));
                  progMem[i] = encR(rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                    5'($urandom_range(0, 7)));
               end
               4: begin
                  rop = 6'($urandom_range(10, 12));
                  progMem[i] = encI(rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                    16'($urandom));
               end
               5: progMem[i] = encI(OP_LW, 5'd0, 5'($urandom_range(0, 7)),
                                    16'(200 + $urandom_range(0, 31)));
               6: progMem[i] = encI(OP_SW, 5'd0, 5'($urandom_range(0, 7)),
                                    16'(200 + $urandom_range(0, 31)));
               7: begin
                  rop = 6'($urandom_range(13, 14));
                  progMem[i] = encI(rop, 5'($urandom_range(0, 7)), 5'd0,
                                    16'($urandom_range(0, 3)));
               end
               default: progMem[i] = {6'($urandom_range(16, 62)), 26'($urandom)};
            endcase
         end
         for (int i = 0; i < 4; i++) progMem[n + i] = HLT_WORD;
         runModel(expPc);
         tg = $sformatf("rnd%0d", t);
         applyStimulus(tg);
         runToHalt(tg, cyc);
         checkOutput({tg, "_pc"}, pc, expPc);
         for (int r = 1; r < 8; r++)
            checkOutput($sformatf("%s_r%0d", tg, r), dut.regfile[r], mReg[r]);
         for (int d = 200; d < 232; d++)
            checkOutput($sformatf("%s_mem%0d", tg, d), dut.mem[d], mMem[d]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
